// File: rtl/mult_share_pkg.sv
// Shared sizing helpers for the shared-multiplier arbiter and its round-robin arbiter.
package mult_share_pkg;

    function automatic int id_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    function automatic int prod_w(input int n, input int m);
        return n + m - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: R-bit request, rotating priority pointer, one-hot grant plus encoded index.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int R = 4,
    localparam int IW = id_w(R)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [R-1:0]  req,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] ptr;

    // Search starts at ptr and wraps; the first hit wins so at most one grant bit is set.
    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < R; k++) begin
            j = int'(ptr) + k;
            if (j >= R) j = j - R;
            if (en && !grant_valid && req[j]) begin
                grant[j]    = 1'b1;
                grant_idx   = IW'(j);
                grant_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == IW'(R - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// One sign-magnitude multiplier shared by R requesters with round-robin grant and a tagged result slot.
// Define MULT_SHARE_ARB_PIPE_EN to add an operand stage ahead of the multiplier (latency 2).
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int R = 4,
    parameter int N = 8,
    parameter int M = 8,
    localparam int IW = id_w(R),
    localparam int PW = prod_w(N, M)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R-1:0]    req_valid,
    input  logic [R*N-1:0]  req_a,
    input  logic [R*M-1:0]  req_b,
    output logic [R-1:0]    req_ready,
    output logic            rsp_valid,
    output logic [IW-1:0]   rsp_id,
    output logic [PW-1:0]   rsp_o,
    input  logic            rsp_ready
);

    logic          accept;
    logic [R-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;
    logic [N-1:0]  sel_a;
    logic [M-1:0]  sel_b;
    logic [N-1:0]  mul_a;
    logic [M-1:0]  mul_b;
    logic [PW-1:0] product;

    // Grant is suppressed while reset is high so no transfer can be acknowledged then.
    rr_arbiter #(.R(R)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .en          (accept & ~rst),
        .req         (req_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;
    assign sel_a     = req_a[grant_idx*N +: N];
    assign sel_b     = req_b[grant_idx*M +: M];

    // Sign-magnitude multiply: the most-negative code has a zero magnitude, giving a zero product.
    logic [N-1:0]  neg_a;
    logic [M-1:0]  neg_b;
    logic [N-2:0]  mag_a;
    logic [M-2:0]  mag_b;
    logic [PW-2:0] mag_p;

    always_comb begin
        neg_a   = -mul_a;
        neg_b   = -mul_b;
        mag_a   = mul_a[N-1] ? neg_a[N-2:0] : mul_a[N-2:0];
        mag_b   = mul_b[M-1] ? neg_b[M-2:0] : mul_b[M-2:0];
        mag_p   = (PW-1)'(mag_a) * (PW-1)'(mag_b);
        product = (mul_a[N-1] ^ mul_b[M-1]) ? -{1'b0, mag_p} : {1'b0, mag_p};
    end

`ifdef MULT_SHARE_ARB_PIPE_EN
    typedef struct packed {
        logic [IW-1:0] id;
        logic [N-1:0]  a;
        logic [M-1:0]  b;
    } op_bundle_t;

    op_bundle_t stage;
    logic       stage_valid;
    logic       rsp_take;

    assign rsp_take = !rsp_valid || rsp_ready;
    assign accept   = !stage_valid || rsp_take;
    assign mul_a    = stage.a;
    assign mul_b    = stage.b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage       <= '0;
        end else if (accept) begin
            stage_valid <= grant_valid;
            if (grant_valid) begin
                stage <= '{id: grant_idx, a: sel_a, b: sel_b};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_o     <= '0;
        end else if (rsp_take) begin
            rsp_valid <= stage_valid;
            if (stage_valid) begin
                rsp_id <= stage.id;
                rsp_o  <= product;
            end
        end
    end
`else
    assign accept = !rsp_valid || rsp_ready;
    assign mul_a  = sel_a;
    assign mul_b  = sel_b;

    // A grant overwrites the slot even while it drains, so back-to-back results have no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_o     <= '0;
        end else if (grant_valid) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant_idx;
            rsp_o     <= product;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
`endif

endmodule
